// File: rtl/spaceinv_pkg.sv
// Shared types and screen geometry for the Space Invaders VGA peripheral.
package spaceinv_pkg;

    typedef enum logic [1:0] {
        FS_IDLE     = 2'd0,
        FS_SHOOT    = 2'd1,
        FS_COOLDOWN = 2'd2,
        FS_WAIT_REL = 2'd3
    } fire_state_t;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned PLAYER_W     = 16;
    localparam int unsigned NUM_MISSILES = 8;
    localparam int unsigned COL_W        = 12;
    localparam int unsigned COL_MAX      = SCREEN_W - PLAYER_W;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// only follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 315000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/player_input_ctrl.sv
// Player control stage: debounced buttons drive a clamped, rate-limited column
// and a fire FSM that toggles the lowest free missile slot.
module player_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 315000,
    parameter int unsigned MOVE_PERIOD     = 250000,
    parameter int unsigned STEP            = 2,
    parameter int unsigned COL_MIN         = 0,
    parameter int unsigned COL_MAX         = spaceinv_pkg::COL_MAX,
    parameter int unsigned COL_RESET       = 312,
    parameter int unsigned FIRE_COOLDOWN   = 3150000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  btn_left,
    input  logic                                  btn_right,
    input  logic                                  btn_fire,
    input  logic [spaceinv_pkg::NUM_MISSILES-1:0] missle_en_xor,
    output logic [spaceinv_pkg::COL_W-1:0]        btn_col,
    output logic [spaceinv_pkg::NUM_MISSILES-1:0] btn_missle_en,
    output logic                                  fire_pulse
);

    import spaceinv_pkg::*;

    localparam int unsigned     MW        = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [MW-1:0]   MOVE_LAST = MW'(MOVE_PERIOD - 1);
    localparam int unsigned     CDW       = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam logic [CDW-1:0]  CD_LOAD   = CDW'(FIRE_COOLDOWN - 1);

    logic w_left;
    logic w_right;
    logic w_fire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_left),
        .o_level (w_left)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_right),
        .o_level (w_right)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_fire),
        .o_level (w_fire)
    );

    fire_state_t              r_state;
    fire_state_t              w_state_next;
    logic                     r_fire_d;
    logic                     w_fire_rise;
    logic [CDW-1:0]           r_cd_cnt;
    logic [NUM_MISSILES-1:0]  r_missle_en;
    logic                     r_fire_pulse;
    logic [COL_W-1:0]         r_col;
    logic [COL_W-1:0]         w_col_next;
    logic [MW-1:0]            r_move_cnt;
    logic                     w_move_tick;
    logic [NUM_MISSILES-1:0]  w_free;
    logic [NUM_MISSILES-1:0]  w_slot;
    logic                     w_claim;

    assign w_move_tick = (r_move_cnt == MOVE_LAST);
    assign w_fire_rise = w_fire & ~r_fire_d;
    assign w_free      = ~missle_en_xor;
    // x & -x isolates the lowest set bit: one-hot of the lowest free slot
    assign w_slot      = w_free & ((~w_free) + NUM_MISSILES'(1));

    // Bounds are checked in 13 bits so neither direction can wrap.
    always_comb begin
        w_col_next = r_col;
        if (w_move_tick) begin
            if (w_left && !w_right) begin
                if ({1'b0, r_col} < 13'(COL_MIN + STEP))
                    w_col_next = COL_W'(COL_MIN);
                else
                    w_col_next = r_col - COL_W'(STEP);
            end else if (w_right && !w_left) begin
                if (({1'b0, r_col} + 13'(STEP)) > 13'(COL_MAX))
                    w_col_next = COL_W'(COL_MAX);
                else
                    w_col_next = r_col + COL_W'(STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= FS_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_claim      = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (w_fire_rise)
                    w_state_next = FS_SHOOT;
            end
            FS_SHOOT: begin
                if (w_free != '0) begin
                    w_claim      = 1'b1;
                    w_state_next = FS_COOLDOWN;
                end else begin
                    w_state_next = FS_WAIT_REL;
                end
            end
            FS_COOLDOWN: begin
                if (r_cd_cnt == '0)
                    w_state_next = FS_WAIT_REL;
            end
            FS_WAIT_REL: begin
                if (!w_fire)
                    w_state_next = FS_IDLE;
            end
            default: w_state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fire_d     <= 1'b0;
            r_cd_cnt     <= '0;
            r_missle_en  <= '0;
            r_fire_pulse <= 1'b0;
            r_col        <= COL_W'(COL_RESET);
            r_move_cnt   <= '0;
        end else begin
            r_fire_d     <= w_fire;
            r_fire_pulse <= w_claim;
            r_col        <= w_col_next;

            if (w_move_tick)
                r_move_cnt <= '0;
            else
                r_move_cnt <= r_move_cnt + MW'(1);

            if (w_claim) begin
                r_missle_en <= r_missle_en ^ w_slot;
                r_cd_cnt    <= CD_LOAD;
            end else if (r_state == FS_COOLDOWN && r_cd_cnt != '0) begin
                r_cd_cnt <= r_cd_cnt - CDW'(1);
            end
        end
    end

    assign btn_col       = r_col;
    assign btn_missle_en = r_missle_en;
    assign fire_pulse    = r_fire_pulse;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with short debounce/move/cooldown periods
// and a model of player's in-flight mask (btn_missle_en XOR slots player has cleared).
module tb_player_input_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    logic [7:0]  missle_en_xor;
    logic [11:0] btn_col;
    logic [7:0]  btn_missle_en;
    logic        fire_pulse;
    logic [7:0]  r_adj;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int base;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MOVE_PERIOD     (8),
        .STEP            (2),
        .COL_MIN         (0),
        .COL_MAX         (624),
        .COL_RESET       (312),
        .FIRE_COOLDOWN   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_fire      (btn_fire),
        .missle_en_xor (missle_en_xor),
        .btn_col       (btn_col),
        .btn_missle_en (btn_missle_en),
        .fire_pulse    (fire_pulse)
    );

    assign missle_en_xor = btn_missle_en ^ r_adj;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (fire_pulse === 1'b1)
            pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [11:0] target, input int budget, input string tag);
        int k = 0;
        while (btn_col !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(btn_col), 32'(target));
    endtask

    initial begin
        rst       = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_fire  = 1'b0;
        r_adj     = 8'h00;

        cyc(3);
        check("rst_col",   32'(btn_col), 32'd312);
        check("rst_en",    32'(btn_missle_en), 32'h00);
        check("rst_pulse", 32'(fire_pulse), 32'd0);
        rst = 1'b0;
        cyc(2);

        // short glitch on fire
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(3); btn_fire = 1'b0; cyc(20);
        check("glitch_pulse", 32'(pulse_cnt - base), 32'd0);
        check("glitch_en",    32'(btn_missle_en), 32'h00);

        // 10-cycle press: toggle lands 8 edges after the raw edge
        base = pulse_cnt;
        btn_fire = 1'b1;
        cyc(7);
        check("lat_pre_pulse", 32'(fire_pulse), 32'd0);
        check("lat_pre_en",    32'(btn_missle_en), 32'h00);
        cyc(1);
        check("lat_pulse", 32'(fire_pulse), 32'd1);
        check("lat_en",    32'(btn_missle_en), 32'h01);
        cyc(2); btn_fire = 1'b0; cyc(40);
        check("press_pulse_cnt", 32'(pulse_cnt - base), 32'd1);

        // mask 0x07 -> slot 3
        r_adj = 8'h06; cyc(1);
        check("mask07", 32'(missle_en_xor), 32'h07);
        btn_fire = 1'b1; cyc(8);
        check("slot3_en",    32'(btn_missle_en), 32'h09);
        check("slot3_pulse", 32'(fire_pulse), 32'd1);
        cyc(1);
        check("slot3_mask", 32'(missle_en_xor), 32'h0F);
        cyc(1); btn_fire = 1'b0; cyc(40);

        // all slots busy: shot dropped, held fire never retries
        r_adj = 8'hF6;
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(30);
        check("full_pulse", 32'(pulse_cnt - base), 32'd0);
        check("full_en",    32'(btn_missle_en), 32'h09);
        r_adj = 8'hE6; cyc(20);
        check("full_hold_no_retry", 32'(pulse_cnt - base), 32'd0);
        btn_fire = 1'b0; cyc(20);
        btn_fire = 1'b1; cyc(10);
        check("after_rel_pulse", 32'(pulse_cnt - base), 32'd1);
        check("after_rel_en",    32'(btn_missle_en), 32'h19);
        btn_fire = 1'b0; cyc(40);

        // long hold gives one shot
        r_adj = 8'h00;
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(100); btn_fire = 1'b0;
        check("hold100_pulse", 32'(pulse_cnt - base), 32'd1);
        check("hold100_en",    32'(btn_missle_en), 32'h1B);
        cyc(30);

        // re-press inside cooldown is dropped
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(8);
        btn_fire = 1'b0; cyc(5);
        btn_fire = 1'b1; cyc(10);
        btn_fire = 1'b0; cyc(60);
        check("cd_ignore_pulse", 32'(pulse_cnt - base), 32'd1);
        check("cd_ignore_en",    32'(btn_missle_en), 32'h1F);
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(10); btn_fire = 1'b0; cyc(40);
        check("cd_second_pulse", 32'(pulse_cnt - base), 32'd1);
        check("cd_second_en",    32'(btn_missle_en), 32'h3F);

        // shot coincident with a left move tick
        btn_left = 1'b1;
        wait_col(12'd310, 40, "conc_first_step");
        btn_fire = 1'b1;
        cyc(7);
        check("conc_pre_col", 32'(btn_col), 32'd310);
        check("conc_pre_en",  32'(btn_missle_en), 32'h3F);
        cyc(1);
        check("conc_col",   32'(btn_col), 32'd308);
        check("conc_en",    32'(btn_missle_en), 32'h7F);
        check("conc_pulse", 32'(fire_pulse), 32'd1);
        btn_left = 1'b0;
        cyc(2); btn_fire = 1'b0; cyc(40);

        // right clamp
        btn_right = 1'b1;
        wait_col(12'd620, 2000, "mv_reach_620");
        cyc(8); check("mv_r1", 32'(btn_col), 32'd622);
        cyc(8); check("mv_r2", 32'(btn_col), 32'd624);
        cyc(8); check("mv_r3", 32'(btn_col), 32'd624);
        btn_right = 1'b0; btn_left = 1'b1;

        // both held: hold
        wait_col(12'd300, 2000, "mv_reach_300");
        btn_right = 1'b1;
        cyc(8);  check("mv_both1", 32'(btn_col), 32'd300);
        cyc(8);  check("mv_both2", 32'(btn_col), 32'd300);
        cyc(8);  check("mv_both3", 32'(btn_col), 32'd300);
        btn_right = 1'b0;

        // left clamp
        wait_col(12'd2, 2000, "mv_reach_2");
        cyc(8); check("mv_l1", 32'(btn_col), 32'd0);
        cyc(8); check("mv_l2", 32'(btn_col), 32'd0);
        btn_left = 1'b0; cyc(10);

        // reset while the FSM sits in SHOOT
        base = pulse_cnt;
        btn_fire = 1'b1; cyc(7);
        rst = 1'b1; btn_fire = 1'b0;
        cyc(1);
        check("midrst_col",   32'(btn_col), 32'd312);
        check("midrst_en",    32'(btn_missle_en), 32'h00);
        check("midrst_pulse", 32'(fire_pulse), 32'd0);
        check("midrst_cnt",   32'(pulse_cnt - base), 32'd0);
        cyc(2); rst = 1'b0; cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
